up_axi_master: RTL

UP_AXI_MASTER -- requirements
Module: up_axi_master

---
 rtl/up_axi_master_if.sv | 37 +++
 rtl/up_axi_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/up_axi_master_if.sv
// AXI4-Lite bus bundle between the up_axi_master bridge and its slave.
// The master modport drives the request channels; the slave modport drives the responses.
interface up_axi_master_if #(
    parameter int AXI_ADDRESS_WIDTH = 16
);
    logic                         awvalid;
    logic                         awready;
    logic [AXI_ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]                   awprot;
    logic                         wvalid;
    logic                         wready;
    logic [31:0]                  wdata;
    logic [3:0]                   wstrb;
    logic                         bvalid;
    logic                         bready;
    logic [1:0]                   bresp;
    logic                         arvalid;
    logic                         arready;
    logic [AXI_ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]                   arprot;
    logic                         rvalid;
    logic                         rready;
    logic [31:0]                  rdata;
    logic [1:0]                   rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/up_axi_master.sv
// Bridges single-word microprocessor read/write pulses onto an AXI4-Lite master port,
// one transaction at a time, with a per-transaction timeout that fakes an error response.
module up_axi_master #(
    parameter int          AXI_ADDRESS_WIDTH = 16,
    parameter int          TIMEOUT_CYCLES    = 1024,
    parameter logic [31:0] ERR_RDATA         = 32'hdead_dead
) (
    input  logic                         up_clk,
    input  logic                         up_rstn,
    input  logic                         up_wreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
    input  logic [31:0]                  up_wdata,
    output logic                         up_wack,
    output logic                         up_werr,
    input  logic                         up_rreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
    output logic [31:0]                  up_rdata,
    output logic                         up_rack,
    output logic                         up_rerr,
    up_axi_master_if.master              m_axi
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                       state;
    logic [CNT_W-1:0]             cnt;
    logic                         wr_full;
    logic                         rd_full;
    logic [AXI_ADDRESS_WIDTH-3:0] wr_addr;
    logic [31:0]                  wr_data;
    logic [AXI_ADDRESS_WIDTH-3:0] rd_addr;
    logic                         serve_wr;
    logic                         awvalid;
    logic                         wvalid;
    logic                         bready;
    logic                         arvalid;
    logic                         rready;
    logic                         timeout;

    assign timeout = (cnt == CNT_LAST);

    // The slots stay loaded until the transaction retires, so they double as the bus registers.
    assign m_axi.awvalid = awvalid;
    assign m_axi.awaddr  = {wr_addr, 2'b00};
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.wdata   = wr_data;
    assign m_axi.wstrb   = 4'hf;
    assign m_axi.bready  = bready;
    assign m_axi.arvalid = arvalid;
    assign m_axi.araddr  = {rd_addr, 2'b00};
    assign m_axi.arprot  = 3'b000;
    assign m_axi.rready  = rready;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_full  <= 1'b0;
            rd_full  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_addr  <= '0;
            serve_wr <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            up_wack  <= 1'b0;
            up_werr  <= 1'b0;
            up_rack  <= 1'b0;
            up_rerr  <= 1'b0;
            up_rdata <= '0;
        end else begin
            if (up_wreq && !wr_full) begin
                wr_full <= 1'b1;
                wr_addr <= up_waddr;
                wr_data <= up_wdata;
            end
            if (up_rreq && !rd_full) begin
                rd_full <= 1'b1;
                rd_addr <= up_raddr;
            end
            up_wack <= 1'b0;
            up_rack <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    // An arriving pulse is served at once so the bus sees it on the next cycle.
                    if (wr_full || up_wreq) begin
                        state    <= WR;
                        serve_wr <= 1'b1;
                        awvalid  <= 1'b1;
                        wvalid   <= 1'b1;
                    end else if (rd_full || up_rreq) begin
                        state    <= RD_ADDR;
                        serve_wr <= 1'b0;
                        arvalid  <= 1'b1;
                    end
                end
                WR: begin
                    if (timeout) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                        state   <= DONE;
                        up_wack <= 1'b1;
                        up_werr <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (m_axi.awready) awvalid <= 1'b0;
                        if (m_axi.wready)  wvalid  <= 1'b0;
                        if ((!awvalid || m_axi.awready) && (!wvalid || m_axi.wready)) begin
                            state  <= WR_RESP;
                            bready <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (timeout) begin
                        bready  <= 1'b0;
                        state   <= DONE;
                        up_wack <= 1'b1;
                        up_werr <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (m_axi.bvalid) begin
                            bready  <= 1'b0;
                            state   <= DONE;
                            up_wack <= 1'b1;
                            up_werr <= (m_axi.bresp != 2'b00);
                        end
                    end
                end
                RD_ADDR: begin
                    if (timeout) begin
                        arvalid  <= 1'b0;
                        state    <= DONE;
                        up_rack  <= 1'b1;
                        up_rerr  <= 1'b1;
                        up_rdata <= ERR_RDATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (m_axi.arready) begin
                            arvalid <= 1'b0;
                            rready  <= 1'b1;
                            state   <= RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (timeout) begin
                        rready   <= 1'b0;
                        state    <= DONE;
                        up_rack  <= 1'b1;
                        up_rerr  <= 1'b1;
                        up_rdata <= ERR_RDATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (m_axi.rvalid) begin
                            rready   <= 1'b0;
                            state    <= DONE;
                            up_rack  <= 1'b1;
                            up_rerr  <= (m_axi.rresp != 2'b00);
                            up_rdata <= (m_axi.rresp != 2'b00) ? ERR_RDATA : m_axi.rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (serve_wr) wr_full <= 1'b0;
                    else          rd_full <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
